osc_freq_meter: RTL and testbench
=================================

Name: osc_freq_meter

Overview:
- Downstream consumer of the free-running ring-oscillator stage.
- Drives the oscillator's enable line and samples its asynchronous clock output.
- Counts oscillator rising edges over a fixed gate window of reference-clock cycles, then reports the latched count with a one-cycle valid pulse.
- Used to measure oscillator frequency on the lab board: f_osc = COUNT * f_CLK / GATE_CYCLES.

Parameters:
- GATE_CYCLES, 1000, measurement window length in CLK cycles (>=1).
- SETTLE_CYCLES, 16, CLK cycles the oscillator runs after enable before counting starts (>=1).
- CNT_W, 16, width of the edge counter and the COUNT output.
- TMR_W, 16, width of the internal settle/gate timer; must hold max(GATE_CYCLES, SETTLE_CYCLES).

Ports:
- CLK  input  1  reference clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  single-cycle request to begin a measurement.
- OSC_IN  input  1  oscillator output; asynchronous to CLK.
- OSC_ENA  output  1  enable to the oscillator stage.
- BUSY  output  1  high whenever the FSM is not in IDLE.
- VALID  output  1  one-cycle pulse when COUNT is updated.
- COUNT  output  CNT_W  latched rising-edge count of the last measurement.
- OVERFLOW  output  1  set if the last measurement saturated COUNT.

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is synchronous and active-high.
- Reset values: state=IDLE, OSC_ENA=0, BUSY=0, VALID=0, COUNT=0, OVERFLOW=0. Synchronizer flops, edge register, timer and edge counter all clear to 0.
- Synchronizer:
  - OSC_IN passes through two flops (s1, s2) plus an edge flop (s3).
  - rise = s2 & ~s3.
  - A 0->1 transition on OSC_IN is recognised as rise 2 cycles after it is sampled by s1.
  - The chain runs in every state.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
  - IDLE: OSC_ENA=0. START=1 -> SETTLE; timer loaded with SETTLE_CYCLES-1; edge counter cleared.
  - SETTLE: OSC_ENA=1. Timer decrements each cycle. When timer==0 -> MEASURE; timer loaded with GATE_CYCLES-1.
  - MEASURE: OSC_ENA=1. Each cycle with rise=1 increments the edge counter. When timer==0 (last gate cycle, its rise still counted) -> DONE.
  - DONE: lasts one cycle, then -> IDLE. OSC_ENA=0, VALID=1; COUNT and OVERFLOW are loaded from the counter in this cycle.
- Timing, for START sampled at cycle t:
  - SETTLE covers t+1..t+SETTLE_CYCLES.
  - MEASURE covers the next GATE_CYCLES cycles.
  - VALID=1 at cycle t+SETTLE_CYCLES+GATE_CYCLES+1.
  - BUSY is high from t+1 through the DONE cycle.
- Counting rules:
  - Only rise events in MEASURE cycles are counted. Edges during SETTLE or DONE are ignored.
  - The counter saturates at 2^CNT_W-1; any further rise sets an internal overflow flag.
  - The overflow flag is cleared on entry to SETTLE.
- Output hold: COUNT and OVERFLOW hold their values until the next DONE or RST.
- START while BUSY is ignored; it does not restart or extend the measurement.
- RST mid-operation (any state): next cycle is IDLE with all reset values, including COUNT=0; no VALID is produced.
- Frequency limit: accuracy requires f_osc < f_CLK/2. Higher frequencies produce an under-count; no error flag is raised for this.

Test Plan:
- Reset: assert RST 2 cycles with OSC_IN toggling -> OSC_ENA=0, BUSY=0, VALID=0, COUNT=0, OVERFLOW=0.
- Nominal (GATE_CYCLES=100, SETTLE_CYCLES=4, CNT_W=8): OSC_IN square wave driven synchronously with period 10 CLK; START pulse at cycle t -> OSC_ENA high t+1..t+104, VALID at t+105 exactly one cycle, COUNT=10, OVERFLOW=0.
- Stuck oscillator (same params): OSC_IN held at 0 -> VALID at t+105, COUNT=0.
- Saturation (CNT_W=4, GATE_CYCLES=100): OSC_IN period 4 CLK (25 edges) -> COUNT=15, OVERFLOW=1. A following run with period 10 -> COUNT=10, OVERFLOW=0.
- START while busy: second START during MEASURE -> single VALID at t+105, count unchanged. START in the cycle after DONE begins a new run.
- Reset mid-MEASURE after a prior COUNT=10: RST at t+50 -> IDLE, OSC_ENA=0, COUNT=0, no VALID. A fresh START then completes normally.

Source files
------------

// File: rtl/osc_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, lets it settle, then
// counts synchronised rising edges over a fixed window of reference-clock cycles.
module osc_freq_meter #(
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int TMR_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_osc_in,
  output logic             o_osc_ena,
  output logic             o_busy,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             w_rise;
  logic [TMR_W-1:0] r_timer;
  logic             w_timer_zero;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ovf_next;
  logic             w_count_evt;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  assign w_rise       = r_s2 & ~r_s3;
  assign w_timer_zero = (r_timer == '0);
  assign w_count_evt  = (r_state == S_MEASURE) && w_rise;
  assign w_cnt_sat    = (r_edge_cnt == CNT_MAX);
  // Saturating increment; a rise arriving at full scale only flags overflow.
  assign w_cnt_next   = (w_count_evt && !w_cnt_sat) ? r_edge_cnt + 1'b1 : r_edge_cnt;
  assign w_ovf_next   = r_ovf | (w_count_evt && w_cnt_sat);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_next = S_SETTLE;
      S_SETTLE:  if (w_timer_zero) w_state_next = S_MEASURE;
      S_MEASURE: if (w_timer_zero) w_state_next = S_DONE;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_osc_ena = (r_state == S_SETTLE) || (r_state == S_MEASURE);
    o_busy    = (r_state != S_IDLE);
    o_valid   = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_timer    <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_s1 <= i_osc_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_timer    <= SETTLE_LOAD;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_timer <= w_timer_zero ? GATE_LOAD : r_timer - 1'b1;
        end
        S_MEASURE: begin
          r_edge_cnt <= w_cnt_next;
          r_ovf      <= w_ovf_next;
          if (w_timer_zero) begin
            // Latch including the final gate cycle's rise so COUNT is valid in DONE.
            r_count    <= w_cnt_next;
            r_overflow <= w_ovf_next;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter: two instances (8-bit and 4-bit counters)
// share stimulus so nominal and saturating behaviour are checked side by side.
`timescale 1ns/1ps
module tb_osc_freq_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       osc;
  logic       ena8, busy8, valid8, ovf8;
  logic [7:0] count8;
  logic       ena4, busy4, valid4, ovf4;
  logic [3:0] count4;

  int n_assert = 0;
  int n_fail   = 0;
  int osc_period = 0;
  int ph = 0;

  always #5 clk = ~clk;

  osc_freq_meter #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(8), .TMR_W(16)
  ) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_osc_in(osc),
    .o_osc_ena(ena8), .o_busy(busy8), .o_valid(valid8),
    .o_count(count8), .o_overflow(ovf8)
  );

  osc_freq_meter #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(4), .TMR_W(16)
  ) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_osc_in(osc),
    .o_osc_ena(ena4), .o_busy(busy4), .o_valid(valid4),
    .o_count(count4), .o_overflow(ovf4)
  );

  // Oscillator model: square wave of osc_period CLK cycles, updated on falling edges.
  initial begin
    osc = 1'b0;
    forever begin
      @(negedge clk);
      if (osc_period == 0) begin
        osc = 1'b0;
        ph  = 0;
      end else begin
        ph  = (ph + 1) % osc_period;
        osc = (ph < osc_period / 2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One measurement: START sampled at the edge ending the current cycle (cycle t).
  task automatic run(input string name, input bit busy_start, input int abort_at,
                     input logic [7:0] exp8, input logic exp_ovf8,
                     input logic [3:0] exp4, input logic exp_ovf4);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 104; n++) begin
      chk({name, " ena/busy/valid8"}, {ena8, busy8, valid8}, 3'b110);
      chk({name, " ena/busy/valid4"}, {ena4, busy4, valid4}, 3'b110);
      if (abort_at == n) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk({name, " abort outputs8"}, {ena8, busy8, valid8, ovf8, count8}, 12'h000);
        chk({name, " abort outputs4"}, {ena4, busy4, valid4, ovf4, count4}, 8'h00);
        for (int k = 0; k < 60; k++) begin
          step();
          chk({name, " abort idle8"}, {busy8, valid8}, 2'b00);
          chk({name, " abort idle4"}, {busy4, valid4}, 2'b00);
        end
        return;
      end
      start = (busy_start && n == 50);
      step();
    end
    start = 1'b0;
    chk({name, " done ena/busy/valid8"}, {ena8, busy8, valid8}, 3'b011);
    chk({name, " done ena/busy/valid4"}, {ena4, busy4, valid4}, 3'b011);
    chk({name, " count8"}, count8, exp8);
    chk({name, " overflow8"}, ovf8, exp_ovf8);
    chk({name, " count4"}, count4, exp4);
    chk({name, " overflow4"}, ovf4, exp_ovf4);
    step();
    chk({name, " post busy/valid8"}, {busy8, valid8}, 2'b00);
    chk({name, " post busy/valid4"}, {busy4, valid4}, 2'b00);
    chk({name, " hold count8"}, {ovf8, count8}, {exp_ovf8, exp8});
    chk({name, " hold count4"}, {ovf4, count4}, {exp_ovf4, exp4});
    $display("run %s: count8=%0d ovf8=%0d count4=%0d ovf4=%0d", name, count8, ovf8, count4, ovf4);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    osc_period = 2;
    step();
    step();
    chk("reset outputs8", {ena8, busy8, valid8, ovf8, count8}, 12'h000);
    chk("reset outputs4", {ena4, busy4, valid4, ovf4, count4}, 8'h00);
    rst = 1'b0;
    $display("reset: ena8=%0d busy8=%0d valid8=%0d count8=%0d", ena8, busy8, valid8, count8);

    osc_period = 10;
    idle(12);
    run("nominal", 1'b0, 0, 8'd10, 1'b0, 4'd10, 1'b0);

    osc_period = 0;
    idle(12);
    run("stuck", 1'b0, 0, 8'd0, 1'b0, 4'd0, 1'b0);

    osc_period = 4;
    idle(12);
    run("saturate", 1'b0, 0, 8'd25, 1'b0, 4'd15, 1'b1);

    osc_period = 10;
    idle(12);
    run("after_sat", 1'b0, 0, 8'd10, 1'b0, 4'd10, 1'b0);
    // Started in the cycle right after DONE, with a stray START mid-gate.
    run("busy_start", 1'b1, 0, 8'd10, 1'b0, 4'd10, 1'b0);

    idle(3);
    run("abort", 1'b0, 50, 8'd0, 1'b0, 4'd0, 1'b0);
    idle(3);
    run("fresh", 1'b0, 0, 8'd10, 1'b0, 4'd10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
